// File: rtl/apb_wait_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : apb_wait_ram_slave
// Brief    : APB completer backed by a byte-wide register RAM, with
//            configurable wait states, out-of-range error response and a
//            saturating error counter.
// Revision : 1.0 - initial release
// ============================================================================
module apb_wait_ram_slave #(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr,
    output logic [7:0] err_cnt
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] C_WAIT   = 4'(WAIT_STATES);
    localparam logic [8:0] C_DEPTH  = 9'(DEPTH);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACCESS = 1'b1;

    logic [0:0]    r_state;
    logic [3:0]    r_cnt;
    logic [7:0]    r_prdata;
    logic          r_pready;
    logic          r_pslverr;
    logic [7:0]    r_err_cnt;
    logic [7:0]    r_ram [DEPTH];

    logic          w_legal;
    logic [AW-1:0] w_idx;
    logic [7:0]    w_rd_data;

    assign w_legal = ({1'b0, paddr} < C_DEPTH);
    assign w_idx   = paddr[AW-1:0];

    // Writes leave prdata untouched; errored transfers always return zero.
    assign w_rd_data = !w_legal ? 8'h00 :
                       pwrite   ? r_prdata : r_ram[w_idx];

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_prdata  <= 8'h00;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_err_cnt <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                r_ram[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    // psel with penable already high here is a protocol error and is ignored.
                    if (psel && !penable) begin
                        r_state  <= S_ACCESS;
                        r_cnt    <= C_WAIT;
                        r_pready <= (WAIT_STATES == 0);
                        if (WAIT_STATES == 0) begin
                            r_prdata  <= w_rd_data;
                            r_pslverr <= ~w_legal;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!psel) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= 4'd0;
                        r_pready  <= 1'b0;
                        r_pslverr <= 1'b0;
                    end else if (penable) begin
                        if (!r_pready) begin
                            r_cnt <= r_cnt - 4'd1;
                            if (r_cnt <= 4'd1) begin
                                r_pready  <= 1'b1;
                                r_prdata  <= w_rd_data;
                                r_pslverr <= ~w_legal;
                            end
                        end else begin
                            if (pwrite && w_legal) begin
                                r_ram[w_idx] <= pwdata;
                            end
                            if (r_pslverr && (r_err_cnt != 8'hFF)) begin
                                r_err_cnt <= r_err_cnt + 8'd1;
                            end
                            r_pready  <= 1'b0;
                            r_pslverr <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign prdata  = r_prdata;
    assign pready  = r_pready;
    assign pslverr = r_pslverr;
    assign err_cnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_apb_wait_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_wait_ram_slave
// Brief    : Directed, table-driven bench for apb_wait_ram_slave; a WAIT_STATES=1
//            and a WAIT_STATES=0 instance share one APB bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_wait_ram_slave;

    logic       clk = 1'b0;
    logic       preset;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;

    logic [7:0] prdata1, prdata0, err_cnt1, err_cnt0;
    logic       pready1, pready0, pslverr1, pslverr0;

    logic       use0;
    logic       m_pready, m_pslverr;
    logic [7:0] m_prdata, m_err_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    apb_wait_ram_slave #(.DEPTH(64), .WAIT_STATES(1)) dut (
        .pclk(clk), .preset(preset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata1), .pready(pready1), .pslverr(pslverr1), .err_cnt(err_cnt1)
    );

    apb_wait_ram_slave #(.DEPTH(64), .WAIT_STATES(0)) dut0 (
        .pclk(clk), .preset(preset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0), .err_cnt(err_cnt0)
    );

    assign m_pready  = use0 ? pready0  : pready1;
    assign m_pslverr = use0 ? pslverr0 : pslverr1;
    assign m_prdata  = use0 ? prdata0  : prdata1;
    assign m_err_cnt = use0 ? err_cnt0 : err_cnt1;

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        logic       exp_err;
        logic [7:0] exp_ecnt;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Called at a negedge; leaves the bus idle at the negedge after completion
    // so a following call forms a back-to-back transfer.
    task automatic xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic err, output int waits,
                        output logic one, output logic [7:0] ecnt);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        waits = 0;
        while (!m_pready && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        rd  = m_prdata;
        err = m_pslverr;
        @(negedge clk);
        one  = !m_pready;
        ecnt = m_err_cnt;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic abort_xfer(input logic [7:0] a, input logic [7:0] d, input logic late,
                              input logic exp_err);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        chk("abort_pready_low", 32'(m_pready), 32'd0);
        if (late) begin
            @(negedge clk);
            chk("abort_pready_high", 32'(m_pready), 32'd1);
            chk("abort_pslverr", 32'(m_pslverr), 32'(exp_err));
        end
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("abort_pready_clr", 32'(m_pready), 32'd0);
        chk("abort_pslverr_clr", 32'(m_pslverr), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd, ecnt, exp;
        logic       err, one;
        int         waits;

        vecs[0] = '{1'b0, 8'h05, 8'h00, 8'h00, 1'b0, 8'd0};
        vecs[1] = '{1'b1, 8'h10, 8'hA5, 8'h00, 1'b0, 8'd0};
        vecs[2] = '{1'b0, 8'h10, 8'h00, 8'hA5, 1'b0, 8'd0};
        vecs[3] = '{1'b1, 8'h40, 8'h11, 8'h00, 1'b1, 8'd1};
        vecs[4] = '{1'b1, 8'h3F, 8'h5A, 8'h00, 1'b0, 8'd1};
        vecs[5] = '{1'b0, 8'h3F, 8'h00, 8'h5A, 1'b0, 8'd1};
        vecs[6] = '{1'b1, 8'h00, 8'hC3, 8'h5A, 1'b0, 8'd1};
        vecs[7] = '{1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 8'd2};
        vecs[8] = '{1'b0, 8'h00, 8'h00, 8'hC3, 1'b0, 8'd2};

        use0 = 1'b0;
        preset = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h00; pwdata = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_pready",  32'(pready1),  32'd0);
        chk("rst_pslverr", 32'(pslverr1), 32'd0);
        chk("rst_prdata",  32'(prdata1),  32'd0);
        chk("rst_err_cnt", 32'(err_cnt1), 32'd0);
        chk("rst_pready0", 32'(pready0),  32'd0);
        preset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, err, waits, one, ecnt);
            chk($sformatf("vec%0d_waits", i),  32'(waits), 32'd1);
            chk($sformatf("vec%0d_prdata", i), 32'(rd),    32'(vecs[i].exp_rd));
            chk($sformatf("vec%0d_pslverr", i), 32'(err),  32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_one_cycle", i), 32'(one), 32'd1);
            chk($sformatf("vec%0d_err_cnt", i), 32'(ecnt), 32'(vecs[i].exp_ecnt));
        end

        for (int a = 0; a < 64; a++) begin
            xfer(1'b0, 8'(a), 8'h00, rd, err, waits, one, ecnt);
            exp = (a == 8'h00) ? 8'hC3 : (a == 8'h10) ? 8'hA5 : (a == 8'h3F) ? 8'h5A : 8'h00;
            chk($sformatf("scan_%02h", a), 32'(rd), 32'(exp));
        end
        chk("scan_err_cnt", 32'(err_cnt1), 32'd2);

        abort_xfer(8'h02, 8'hFF, 1'b0, 1'b0);
        abort_xfer(8'h04, 8'h99, 1'b1, 1'b0);
        abort_xfer(8'h80, 8'h55, 1'b1, 1'b1);
        xfer(1'b0, 8'h02, 8'h00, rd, err, waits, one, ecnt);
        chk("abort_rd02", 32'(rd), 32'h00);
        chk("abort_rd02_waits", 32'(waits), 32'd1);
        xfer(1'b0, 8'h04, 8'h00, rd, err, waits, one, ecnt);
        chk("abort_rd04", 32'(rd), 32'h00);
        chk("abort_err_cnt", 32'(ecnt), 32'd2);

        // Leave prdata non-zero so the asynchronous clear is observable.
        xfer(1'b0, 8'h10, 8'h00, rd, err, waits, one, ecnt);
        chk("pre_rst_rd10", 32'(rd), 32'hA5);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h03; pwdata = 8'h77;
        @(negedge clk);
        penable = 1'b1;
        #2 preset = 1'b0;
        #1;
        chk("midrst_pready",  32'(pready1),  32'd0);
        chk("midrst_pslverr", 32'(pslverr1), 32'd0);
        chk("midrst_prdata",  32'(prdata1),  32'd0);
        chk("midrst_err_cnt", 32'(err_cnt1), 32'd0);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        preset = 1'b1;
        @(negedge clk);
        xfer(1'b0, 8'h03, 8'h00, rd, err, waits, one, ecnt);
        chk("midrst_rd03", 32'(rd), 32'h00);
        xfer(1'b0, 8'h10, 8'h00, rd, err, waits, one, ecnt);
        chk("midrst_rd10", 32'(rd), 32'h00);

        use0 = 1'b1;
        xfer(1'b1, 8'h01, 8'h3C, rd, err, waits, one, ecnt);
        chk("ws0_wr_waits", 32'(waits), 32'd0);
        chk("ws0_wr_one_cycle", 32'(one), 32'd1);
        xfer(1'b0, 8'h01, 8'h00, rd, err, waits, one, ecnt);
        chk("ws0_rd_waits", 32'(waits), 32'd0);
        chk("ws0_rd_prdata", 32'(rd), 32'h3C);
        chk("ws0_rd_pslverr", 32'(err), 32'd0);
        xfer(1'b0, 8'h40, 8'h00, rd, err, waits, one, ecnt);
        chk("ws0_oob_pslverr", 32'(err), 32'd1);
        chk("ws0_oob_prdata", 32'(rd), 32'h00);
        use0 = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 254; n++) begin
            xfer(1'b0, 8'hFF, 8'h00, rd, err, waits, one, ecnt);
        end
        chk("sat_err_cnt_fe", 32'(err_cnt1), 32'hFE);
        for (int n = 0; n < 6; n++) begin
            xfer(1'b0, 8'hFF, 8'h00, rd, err, waits, one, ecnt);
        end
        chk("sat_err_cnt_ff", 32'(err_cnt1), 32'hFF);
        chk("sat_pslverr", 32'(err), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_wait_ram_slave.md
Name: apb_wait_ram_slave

Overview:
- APB completer that sits directly downstream of the team's APB master.
- Accepts psel/penable/pwrite/paddr/pwdata from the master and returns prdata/pready/pslverr.
- Backs transfers with an internal byte-wide register RAM.
- Inserts a parameterised number of wait states and flags out-of-range addresses via pslverr.
- Keeps a saturating error counter for debug.

Parameters:
- DEPTH, 64, number of 8-bit RAM locations; valid addresses 0..DEPTH-1 (DEPTH <= 256).
- WAIT_STATES, 1, number of access cycles with pready low before completion (0..15).

Ports:
- pclk  input  1  APB clock; all state changes on the rising edge.
- preset  input  1  asynchronous, active-low reset.
- psel  input  1  slave select from master.
- penable  input  1  access-phase strobe from master.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  8  byte address.
- pwdata  input  8  write data.
- prdata  output  8  read data; valid while pready=1 on a read.
- pready  output  1  transfer-complete handshake.
- pslverr  output  1  error response; valid only while pready=1.
- err_cnt  output  8  saturating count of completed transfers that returned pslverr=1.

Behaviour:
- Reset (preset=0, asynchronous): FSM enters IDLE; pready=0, pslverr=0, prdata=8'h00, err_cnt=0, wait counter=0, all RAM locations cleared to 8'h00. Any in-flight write is dropped.
- FSM states: IDLE, ACCESS. All outputs are registered.
- IDLE:
  - Edge with psel=1, penable=0 (setup phase): go to ACCESS, load cnt=WAIT_STATES, set pready<=(WAIT_STATES==0).
  - If WAIT_STATES==0, also load prdata/pslverr at this same edge (see completion rules).
  - psel=1 and penable=1 seen in IDLE is a protocol error: ignore it and stay in IDLE.
- ACCESS, edge with psel=1, penable=1:
  - pready=0: decrement cnt. When cnt reaches 1→0 transition, set pready<=1 and load prdata/pslverr.
  - pready=1: transfer completes at this edge. Commit a write if legal; set pready<=0, pslverr<=0; return to IDLE.
  - If the completed transfer had pslverr=1, increment err_cnt (saturates at 8'hFF).
- Latency: pready is high in access cycle WAIT_STATES+1. Exactly one cycle of pready per transfer.
- Completion rules (evaluated on paddr/pwrite held stable by the master):
  - paddr >= DEPTH: pslverr=1, write not committed, prdata=8'h00.
  - Legal read: prdata=RAM[paddr]. For a write, prdata holds its previous value.
  - Legal write: RAM[paddr]<=pwdata at the completion edge. A read of the same address in the next transfer returns the new data.
- Abort: psel=0 during ACCESS returns to IDLE immediately, clears pready/pslverr, commits no write and leaves err_cnt unchanged.
- Back-to-back: a setup phase may directly follow the completion edge. The next transfer begins from IDLE on the following edge; there are no extra idle cycles.
- paddr/pwdata changing mid-access is the master's violation. The slave uses the values present at the load/commit edges.
- Reset asserted mid-ACCESS: immediate return to reset values; no partial write.

Test Plan:
- Reset with WAIT_STATES=1: release preset, read addr 8'h05 -> pready high in the 2nd access cycle, prdata=8'h00, pslverr=0, err_cnt=0.
- Write 8'hA5 to 8'h10, then read 8'h10 -> read returns prdata=8'hA5. Each transfer shows exactly one pready-low access cycle, then pready=1 for one cycle.
- Write to 8'h40 with DEPTH=64 -> pslverr=1 with pready. Subsequent read of 8'h00..8'h3F shows no location changed; err_cnt=1.
- WAIT_STATES=0: back-to-back write 8'h3C to 8'h01 then read 8'h01 -> pready high in the first access cycle of each; read prdata=8'h3C.
- Abort: write 8'hFF to 8'h02 with psel dropped after one access cycle (pready still 0) -> FSM returns to IDLE; later read of 8'h02 returns 8'h00.
- Reset mid-write: assert preset=0 during ACCESS of a write of 8'h77 to 8'h03 -> outputs go to 0 asynchronously; after release, read 8'h03 returns 8'h00.
- Error saturation: 260 out-of-range reads -> err_cnt=8'hFF.
